uart_prog_loader: RTL and testbench
===================================

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 Parameter DBIT, default 32: UART word width in bits; it matches the uart block's DBIT.
REQ-002 Parameter ADDR_W, default 8: instruction-memory address width in bits, giving 2^ADDR_W words.
REQ-003 i_clk  input  1  system clock; the block uses one clock, and all logic is on its rising edge.
REQ-004 i_reset  input  1  synchronous reset, active-high.
REQ-005 i_rx_empty  input  1  uart receiver FIFO is empty.
REQ-006 i_r_data  input  DBIT  uart receiver FIFO head word; it is valid whenever i_rx_empty=0 (first-word fall-through).
REQ-007 o_rd_uart  output  1  one-cycle pop of the uart receiver FIFO.
REQ-008 i_tx_full  input  1  uart transmitter FIFO is full.
REQ-009 o_wr_uart  output  1  one-cycle push to the uart transmitter FIFO.
REQ-010 o_w_data  output  DBIT  reply word to the uart transmitter.
REQ-011 o_imem_we  output  1  instruction-memory write enable.
REQ-012 o_imem_addr  output  ADDR_W  instruction-memory write address.
REQ-013 o_imem_data  output  DBIT  instruction-memory write data.
REQ-014 o_cpu_run  output  1  pipeline free-run enable, held high.
REQ-015 o_cpu_step  output  1  single-cycle pipeline advance pulse.
REQ-016 i_cpu_halt  input  1  pipeline reached a halt instruction.
REQ-017 o_busy  output  1  high in every state except IDLE.

Function
REQ-018 Command word format: opcode = bits[31:24], argument N = bits[15:0].
- 0x01 is LOAD.
- 0x02 is RUN.
- 0x03 is STEP.
- Any other opcode is invalid.
REQ-019 FSM states are IDLE, LOAD, RUN, STEP and ACK, and the FSM makes exactly one transition per clock.
REQ-020 In IDLE with i_rx_empty=0, the block pops and decodes the head word in the same cycle:
- o_rd_uart=1 in that cycle.
- The opcode and N are latched.
REQ-021 IDLE next-state after decode:
- LOAD with N>0 goes to LOAD; the remaining-word counter is loaded with N and the address counter is cleared to 0.
- LOAD with N=0 goes to ACK.
- RUN goes to RUN.
- STEP goes to STEP.
- An invalid opcode goes to ACK with the error flag set.
REQ-022 In LOAD, each cycle with i_rx_empty=0 does all of the following in that cycle:
- pulses o_rd_uart;
- drives o_imem_we=1, o_imem_data=i_r_data and o_imem_addr=address counter;
- increments the address counter and decrements the remaining-word counter.
REQ-023 In LOAD with i_rx_empty=1, the block holds state with o_rd_uart=0 and o_imem_we=0 (it stalls with no timeout).
REQ-024 LOAD exits to ACK in the cycle after the last word is written (remaining count reaches 0).
REQ-025 The address counter wraps modulo 2^ADDR_W: for N > 2^ADDR_W, later words overwrite from address 0.
REQ-026 RUN behaviour:
- o_cpu_run=1 from the first RUN cycle onward.
- The block leaves RUN for ACK in the cycle after i_cpu_halt=1 is sampled, and o_cpu_run=0 in ACK.
- The receiver FIFO is not read while in RUN.
REQ-027 STEP: o_cpu_step=1 for exactly one cycle, then the FSM goes to ACK.
REQ-028 ACK reply word format: o_w_data = {status[7:0], opcode[7:0], N[15:0]}.
- status = 0xA5 on success.
- status = 0xEE for an invalid opcode.
REQ-029 ACK transmit handshake:
- With i_tx_full=0, o_wr_uart=1 for one cycle, then the FSM returns to IDLE.
- With i_tx_full=1, o_wr_uart=0 and the FSM stays in ACK, holding o_w_data stable.
REQ-030 o_rd_uart and o_wr_uart are never high in the same cycle, and o_rd_uart is never high while i_rx_empty=1.
REQ-031 o_imem_we, o_rd_uart, o_wr_uart and o_cpu_step are each single-cycle pulses, never held longer than their qualifying condition.

Reset
REQ-032 On i_reset=1 the FSM enters IDLE and all counters and latched fields clear to 0.
REQ-033 After reset, every output is 0 (o_busy=0, o_cpu_run=0, o_w_data=0, o_imem_addr=0).
REQ-034 A reset in any state, including mid-LOAD, mid-RUN or ACK stalled on i_tx_full, aborts the command with no reply word, and no pulse output is asserted in the reset cycle.

Verification
REQ-035 The bench covers the following directed scenarios:
- LOAD: rx words 0x01000003, 0x11, 0x22, 0x33 with gaps -> imem writes (0,0x11),(1,0x22),(2,0x33) -> reply 0xA5010003.
- LOAD N=0: rx 0x01000000 -> no imem write -> reply 0xA5010000 -> IDLE.
- RUN + tx backpressure: rx 0x02000000 -> o_cpu_run held high -> i_cpu_halt pulse -> o_cpu_run=0; with i_tx_full=1 for 5 cycles, o_wr_uart stays 0 and o_w_data=0xA5020000 stays stable until i_tx_full drops.
- STEP and invalid opcode: rx 0x03000000 -> exactly one o_cpu_step pulse -> reply 0xA5030000; rx 0x7F000009 -> reply 0xEE7F0009, with no run, step or imem write.
- Wrap: ADDR_W=2, LOAD N=5 -> the 5th word is written to address 0.
- Reset mid-LOAD: reset after 2 of 4 words -> outputs 0 -> no reply -> the next LOAD writes from address 0.

Source files
------------

// File: rtl/uart_prog_loader.sv
// -----------------------------------------------------------------------------
// uart_prog_loader
//
// Command front-end that sits between a UART (receive and transmit FIFOs) and a
// small pipelined CPU. It takes command words from the receive FIFO. It can
// load a program into instruction memory, free-run the CPU until it halts, or
// single-step the CPU. After each command it sends one reply word on the
// transmit FIFO.
//
// Command word: opcode = bits[31:24], argument N = bits[15:0]
//    0x01 LOAD : the next N receive words go to imem, starting at address 0
//    0x02 RUN  : hold o_cpu_run high until the CPU reports a halt
//    0x03 STEP : give the CPU one o_cpu_step pulse
//    other     : rejected, with an error status in the reply
// Reply word : {status[7:0], opcode[7:0], N[15:0]}
//    status is 0xA5 on success and 0xEE for an unknown opcode.
//
// Ports
//    i_clk        system clock; all logic runs on its rising edge
//    i_reset      synchronous, active-high reset
//    i_rx_empty   receive FIFO is empty
//    i_r_data     receive FIFO head word (first-word fall-through)
//    o_rd_uart    one-cycle pop of the receive FIFO
//    i_tx_full    transmit FIFO is full
//    o_wr_uart    one-cycle push to the transmit FIFO
//    o_w_data     reply word to the transmit FIFO
//    o_imem_we    instruction-memory write enable
//    o_imem_addr  instruction-memory write address
//    o_imem_data  instruction-memory write data
//    o_cpu_run    CPU free-run enable (level)
//    o_cpu_step   CPU single-cycle advance pulse
//    i_cpu_halt   CPU has reached a halt instruction
//    o_busy       a command is in progress (any state other than IDLE)
//
// DBIT must be at least 32, because the command and reply fields use bits
// [31:0]. When DBIT is wider than 32, the reply is zero-extended.
// -----------------------------------------------------------------------------
module uart_prog_loader #(
   parameter int DBIT   = 32,
   parameter int ADDR_W = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_rx_empty,
   input  logic [DBIT-1:0]   i_r_data,
   output logic              o_rd_uart,
   input  logic              i_tx_full,
   output logic              o_wr_uart,
   output logic [DBIT-1:0]   o_w_data,
   output logic              o_imem_we,
   output logic [ADDR_W-1:0] o_imem_addr,
   output logic [DBIT-1:0]   o_imem_data,
   output logic              o_cpu_run,
   output logic              o_cpu_step,
   input  logic              i_cpu_halt,
   output logic              o_busy
);

   // FSM encoding
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LOAD = 3'd1;
   localparam logic [2:0] ST_RUN  = 3'd2;
   localparam logic [2:0] ST_STEP = 3'd3;
   localparam logic [2:0] ST_ACK  = 3'd4;

   // Opcodes and reply status codes
   localparam logic [7:0] OP_LOAD    = 8'h01;
   localparam logic [7:0] OP_RUN     = 8'h02;
   localparam logic [7:0] OP_STEP    = 8'h03;
   localparam logic [7:0] STATUS_OK  = 8'hA5;
   localparam logic [7:0] STATUS_ERR = 8'hEE;

   // Registered state and the fields latched from the command word
   logic [2:0]        r_state;
   logic [7:0]        r_opcode;
   logic [15:0]       r_arg;
   logic              r_err;
   logic [15:0]       r_remain;   // LOAD words still to be written
   logic [ADDR_W-1:0] r_addr;     // next imem write address; wraps modulo 2^ADDR_W

   // Combinational decode of the FIFO head word and the next state
   logic [7:0]        w_opcode;
   logic [15:0]       w_arg;
   logic              w_op_valid;
   logic              w_pop;
   logic              w_write;
   logic [2:0]        w_next_state;
   logic [31:0]       w_reply;

   assign w_opcode   = i_r_data[31:24];
   assign w_arg      = i_r_data[15:0];
   assign w_op_valid = (w_opcode == OP_LOAD) || (w_opcode == OP_RUN) ||
                       (w_opcode == OP_STEP);
   assign w_reply    = {(r_err ? STATUS_ERR : STATUS_OK), r_opcode, r_arg};

   // Next-state logic and the FIFO pop/write strobes.
   // NOTE: every signal written here gets a default first. A path that left a
   // signal unassigned would infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_pop        = 1'b0;
      w_write      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!i_rx_empty) begin
               w_pop = 1'b1;
               case (w_opcode)
                  OP_LOAD: w_next_state = (w_arg != 16'd0) ? ST_LOAD : ST_ACK;
                  OP_RUN:  w_next_state = ST_RUN;
                  OP_STEP: w_next_state = ST_STEP;
                  default: w_next_state = ST_ACK;
               endcase
            end
         end
         ST_LOAD: begin
            // Stall without a timeout while the receive FIFO is empty.
            if (!i_rx_empty) begin
               w_pop   = 1'b1;
               w_write = 1'b1;
               if (r_remain == 16'd1) begin
                  w_next_state = ST_ACK;
               end
            end
         end
         ST_RUN: begin
            if (i_cpu_halt) begin
               w_next_state = ST_ACK;
            end
         end
         ST_STEP: begin
            w_next_state = ST_ACK;
         end
         ST_ACK: begin
            // Hold the reply until the transmit FIFO can take it.
            if (!i_tx_full) begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples values from before the edge and ordering does not matter.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= ST_IDLE;
         r_opcode <= 8'd0;
         r_arg    <= 16'd0;
         r_err    <= 1'b0;
         r_remain <= 16'd0;
         r_addr   <= '0;
      end else begin
         r_state <= w_next_state;
         if ((r_state == ST_IDLE) && w_pop) begin
            r_opcode <= w_opcode;
            r_arg    <= w_arg;
            r_err    <= !w_op_valid;
            r_remain <= w_arg;
            r_addr   <= '0;
         end
         if (w_write) begin
            r_addr   <= r_addr + 1'b1;
            r_remain <= r_remain - 16'd1;
         end
      end
   end

   // Outputs decode from the current state. All of them are forced low during
   // reset, so an aborted command cannot pulse anything (or send a reply) in the
   // reset cycle itself.
   // NOTE: the reset gating is combinational. Because reset is synchronous, the
   // state register still holds its old value during the reset cycle.
   assign o_rd_uart   = w_pop & ~i_reset;
   assign o_imem_we   = w_write & ~i_reset;
   assign o_imem_data = (w_write && !i_reset) ? i_r_data : '0;
   assign o_imem_addr = ((r_state == ST_LOAD) && !i_reset) ? r_addr : '0;
   assign o_cpu_run   = (r_state == ST_RUN) && !i_reset;
   assign o_cpu_step  = (r_state == ST_STEP) && !i_reset;
   assign o_wr_uart   = (r_state == ST_ACK) && !i_tx_full && !i_reset;
   assign o_w_data    = ((r_state == ST_ACK) && !i_reset) ? DBIT'(w_reply) : '0;
   assign o_busy      = (r_state != ST_IDLE) && !i_reset;

endmodule

// File: tb/tb_uart_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_prog_loader
//
// Bench for uart_prog_loader, built with ADDR_W=2 so that address wrap can be
// exercised. A table of per-cycle vectors covers these sequences: LOAD with
// gaps, LOAD N=0, RUN with transmit backpressure, STEP, an invalid opcode, a
// LOAD that wraps the address, and reset during a LOAD. Short hand-written
// sequences cover reset while ACK is stalled, and a STEP whose pulses are
// counted over a bounded window.
// -----------------------------------------------------------------------------
module tb_uart_prog_loader;

   localparam int DBIT   = 32;
   localparam int ADDR_W = 2;

   logic              clk = 1'b0;
   logic              i_reset;
   logic              i_rx_empty;
   logic [DBIT-1:0]   i_r_data;
   logic              o_rd_uart;
   logic              i_tx_full;
   logic              o_wr_uart;
   logic [DBIT-1:0]   o_w_data;
   logic              o_imem_we;
   logic [ADDR_W-1:0] o_imem_addr;
   logic [DBIT-1:0]   o_imem_data;
   logic              o_cpu_run;
   logic              o_cpu_step;
   logic              i_cpu_halt;
   logic              o_busy;

   int n_cmp  = 0;
   int n_fail = 0;

   uart_prog_loader #(.DBIT(DBIT), .ADDR_W(ADDR_W)) dut (
      .i_clk       (clk),
      .i_reset     (i_reset),
      .i_rx_empty  (i_rx_empty),
      .i_r_data    (i_r_data),
      .o_rd_uart   (o_rd_uart),
      .i_tx_full   (i_tx_full),
      .o_wr_uart   (o_wr_uart),
      .o_w_data    (o_w_data),
      .o_imem_we   (o_imem_we),
      .o_imem_addr (o_imem_addr),
      .o_imem_data (o_imem_data),
      .o_cpu_run   (o_cpu_run),
      .o_cpu_step  (o_cpu_step),
      .i_cpu_halt  (i_cpu_halt),
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish within time limit");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        rst;
      logic        empty;
      logic [31:0] rdata;
      logic        txf;
      logic        halt;
      logic        e_rd;
      logic        e_wr;
      logic        e_we;
      logic        e_run;
      logic        e_step;
      logic        e_busy;
      int          e_addr;    // -1: don't care
      logic        wd_care;
      logic [31:0] e_wdata;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic rst, input logic empty, input logic [31:0] rdata,
                               input logic txf, input logic halt,
                               input logic rd, input logic wr, input logic we,
                               input logic run, input logic step, input logic busy,
                               input int addr, input logic wdc, input logic [31:0] wdata);
      vec_t v;
      v.rst = rst; v.empty = empty; v.rdata = rdata; v.txf = txf; v.halt = halt;
      v.e_rd = rd; v.e_wr = wr; v.e_we = we; v.e_run = run; v.e_step = step;
      v.e_busy = busy; v.e_addr = addr; v.wd_care = wdc; v.e_wdata = wdata;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Drive inputs on the falling edge and let the outputs settle before sampling.
   task automatic drive(input logic rst, input logic empty, input logic [31:0] d,
                        input logic txf, input logic halt);
      @(negedge clk);
      i_reset    = rst;
      i_rx_empty = empty;
      i_r_data   = d;
      i_tx_full  = txf;
      i_cpu_halt = halt;
      #1;
      // These rules must hold in every cycle.
      check("inv_rd_wr_exclusive", {31'd0, o_rd_uart & o_wr_uart}, 32'd0);
      check("inv_no_rd_when_empty", {31'd0, o_rd_uart & i_rx_empty}, 32'd0);
   endtask

   int          steps;
   int          got_wr;
   logic [31:0] reply;

   initial begin
      i_reset = 1'b1; i_rx_empty = 1'b1; i_r_data = '0; i_tx_full = 1'b0; i_cpu_halt = 1'b0;
      repeat (2) @(posedge clk);

      //   rst emp rdata         txf hlt  rd wr we run stp bsy addr wdc wdata
      add(1, 1, 32'h0,          0, 0,   0, 0, 0, 0, 0, 0,  0, 1, 32'h0);
      // LOAD N=3 with gaps in the receive stream
      add(0, 0, 32'h01000003,   0, 0,   1, 0, 0, 0, 0, 0, -1, 0, 32'h0);
      add(0, 1, 32'h0,          0, 0,   0, 0, 0, 0, 0, 1, -1, 0, 32'h0);
      add(0, 0, 32'h11,         0, 0,   1, 0, 1, 0, 0, 1,  0, 0, 32'h0);
      add(0, 0, 32'h22,         0, 0,   1, 0, 1, 0, 0, 1,  1, 0, 32'h0);
      add(0, 1, 32'h0,          0, 0,   0, 0, 0, 0, 0, 1, -1, 0, 32'h0);
      add(0, 0, 32'h33,         0, 0,   1, 0, 1, 0, 0, 1,  2, 0, 32'h0);
      add(0, 1, 32'h0,          0, 0,   0, 1, 0, 0, 0, 1, -1, 1, 32'hA5010003);
      add(0, 1, 32'h0,          0, 0,   0, 0, 0, 0, 0, 0, -1, 0, 32'h0);
      // LOAD N=0 goes straight to the reply
      add(0, 0, 32'h01000000,   0, 0,   1, 0, 0, 0, 0, 0, -1, 0, 32'h0);
      add(0, 1, 32'h0,          0, 0,   0, 1, 0, 0, 0, 1, -1, 1, 32'hA5010000);
      add(0, 1, 32'h0,          0, 0,   0, 0, 0, 0, 0, 0, -1, 0, 32'h0);
      // RUN: a waiting receive word is not popped; halt; 5 cycles of tx backpressure
      add(0, 0, 32'h02000000,   0, 0,   1, 0, 0, 0, 0, 0, -1, 0, 32'h0);
      add(0, 0, 32'hDEAD0000,   0, 0,   0, 0, 0, 1, 0, 1, -1, 0, 32'h0);
      add(0, 0, 32'hDEAD0000,   0, 0,   0, 0, 0, 1, 0, 1, -1, 0, 32'h0);
      add(0, 0, 32'hDEAD0000,   0, 1,   0, 0, 0, 1, 0, 1, -1, 0, 32'h0);
      for (int i = 0; i < 5; i++)
         add(0, 0, 32'hDEAD0000, 1, 0,  0, 0, 0, 0, 0, 1, -1, 1, 32'hA5020000);
      add(0, 1, 32'h0,          0, 0,   0, 1, 0, 0, 0, 1, -1, 1, 32'hA5020000);
      add(0, 1, 32'h0,          0, 0,   0, 0, 0, 0, 0, 0, -1, 0, 32'h0);
      // STEP
      add(0, 0, 32'h03000000,   0, 0,   1, 0, 0, 0, 0, 0, -1, 0, 32'h0);
      add(0, 1, 32'h0,          0, 0,   0, 0, 0, 0, 1, 1, -1, 0, 32'h0);
      add(0, 1, 32'h0,          0, 0,   0, 1, 0, 0, 0, 1, -1, 1, 32'hA5030000);
      // Invalid opcode
      add(0, 0, 32'h7F000009,   0, 0,   1, 0, 0, 0, 0, 0, -1, 0, 32'h0);
      add(0, 1, 32'h0,          0, 0,   0, 1, 0, 0, 0, 1, -1, 1, 32'hEE7F0009);
      add(0, 1, 32'h0,          0, 0,   0, 0, 0, 0, 0, 0, -1, 0, 32'h0);
      // LOAD N=5 with ADDR_W=2: the fifth word wraps to address 0
      add(0, 0, 32'h01000005,   0, 0,   1, 0, 0, 0, 0, 0, -1, 0, 32'h0);
      add(0, 0, 32'hA0,         0, 0,   1, 0, 1, 0, 0, 1,  0, 0, 32'h0);
      add(0, 0, 32'hA1,         0, 0,   1, 0, 1, 0, 0, 1,  1, 0, 32'h0);
      add(0, 0, 32'hA2,         0, 0,   1, 0, 1, 0, 0, 1,  2, 0, 32'h0);
      add(0, 0, 32'hA3,         0, 0,   1, 0, 1, 0, 0, 1,  3, 0, 32'h0);
      add(0, 0, 32'hA4,         0, 0,   1, 0, 1, 0, 0, 1,  0, 0, 32'h0);
      add(0, 1, 32'h0,          0, 0,   0, 1, 0, 0, 0, 1, -1, 1, 32'hA5010005);
      add(0, 1, 32'h0,          0, 0,   0, 0, 0, 0, 0, 0, -1, 0, 32'h0);
      // Reset after 2 of 4 words: no reply, and the next LOAD starts at address 0
      add(0, 0, 32'h01000004,   0, 0,   1, 0, 0, 0, 0, 0, -1, 0, 32'h0);
      add(0, 0, 32'hB0,         0, 0,   1, 0, 1, 0, 0, 1,  0, 0, 32'h0);
      add(0, 0, 32'hB1,         0, 0,   1, 0, 1, 0, 0, 1,  1, 0, 32'h0);
      add(1, 0, 32'hB2,         0, 0,   0, 0, 0, 0, 0, 0,  0, 1, 32'h0);
      add(0, 1, 32'h0,          0, 0,   0, 0, 0, 0, 0, 0,  0, 1, 32'h0);
      add(0, 1, 32'h0,          0, 0,   0, 0, 0, 0, 0, 0,  0, 1, 32'h0);
      add(0, 0, 32'h01000001,   0, 0,   1, 0, 0, 0, 0, 0, -1, 0, 32'h0);
      add(0, 0, 32'hC0,         0, 0,   1, 0, 1, 0, 0, 1,  0, 0, 32'h0);
      add(0, 1, 32'h0,          0, 0,   0, 1, 0, 0, 0, 1, -1, 1, 32'hA5010001);
      add(0, 1, 32'h0,          0, 0,   0, 0, 0, 0, 0, 0, -1, 0, 32'h0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].empty, vecs[i].rdata, vecs[i].txf, vecs[i].halt);
         check($sformatf("v%0d rd_uart", i),  {31'd0, o_rd_uart},  {31'd0, vecs[i].e_rd});
         check($sformatf("v%0d wr_uart", i),  {31'd0, o_wr_uart},  {31'd0, vecs[i].e_wr});
         check($sformatf("v%0d imem_we", i),  {31'd0, o_imem_we},  {31'd0, vecs[i].e_we});
         check($sformatf("v%0d cpu_run", i),  {31'd0, o_cpu_run},  {31'd0, vecs[i].e_run});
         check($sformatf("v%0d cpu_step", i), {31'd0, o_cpu_step}, {31'd0, vecs[i].e_step});
         check($sformatf("v%0d busy", i),     {31'd0, o_busy},     {31'd0, vecs[i].e_busy});
         if (vecs[i].e_addr >= 0)
            check($sformatf("v%0d imem_addr", i), {30'd0, o_imem_addr}, vecs[i].e_addr);
         if (vecs[i].e_we)
            check($sformatf("v%0d imem_data", i), o_imem_data, vecs[i].rdata);
         if (vecs[i].wd_care)
            check($sformatf("v%0d w_data", i), o_w_data, vecs[i].e_wdata);
      end

      // Reset while ACK is stalled on a full transmit FIFO: the reply is dropped.
      drive(0, 0, 32'h7F000009, 0, 0);
      check("ackrst pop", {31'd0, o_rd_uart}, 32'd1);
      drive(0, 1, 32'h0, 1, 0);
      check("ackrst stalled wr", {31'd0, o_wr_uart}, 32'd0);
      check("ackrst stalled data", o_w_data, 32'hEE7F0009);
      drive(1, 1, 32'h0, 1, 0);
      check("ackrst reset wr", {31'd0, o_wr_uart}, 32'd0);
      check("ackrst reset data", o_w_data, 32'h0);
      check("ackrst reset busy", {31'd0, o_busy}, 32'd0);
      drive(0, 1, 32'h0, 0, 0);
      check("ackrst after wr", {31'd0, o_wr_uart}, 32'd0);
      check("ackrst after busy", {31'd0, o_busy}, 32'd0);

      // STEP over a bounded window: count the step pulses and capture the reply.
      drive(0, 0, 32'h03000000, 0, 0);
      steps = 0; got_wr = 0; reply = '0;
      for (int c = 0; c < 10; c++) begin
         drive(0, 1, 32'h0, 0, 0);
         if (o_cpu_step) steps++;
         if (o_wr_uart) begin
            got_wr++;
            reply = o_w_data;
         end
      end
      check("step pulse count", steps, 32'd1);
      check("step reply count", got_wr, 32'd1);
      check("step reply word", reply, 32'hA5030000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
